alu_issue: RTL and testbench

- Decode/issue stage directly upstream of the registered 3-bit-op ALU. Accepts one RV32I integer-ALU instruction per cycle and reads the internal 32x32 register file.
- Drives d1/d2/op to the ALU, then writes the ALU result back into the register file two cycles later.
- Tracks the instruction in flight, stalls on read-after-write hazards and bypasses the writeback value.

---
 rtl/alu_issue_pkg.sv | 72 +++++++
 rtl/alu_issue_regfile.sv | 34 +++
 rtl/alu_issue.sv | 106 ++++++++++
 tb/tb_alu_issue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and encodings for the alu_issue decode/issue stage: ALU op codes
// (same numbering as the downstream ALU), RV32I opcode/funct constants and the decoder.
package alu_issue_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int RAW   = $clog2(NREGS);

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_OR  = 3'd2,
      ALU_XOR = 3'd3,
      ALU_AND = 3'd4,
      ALU_SRL = 3'd5,
      ALU_SLL = 3'd6,
      ALU_SLT = 3'd7
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SRL = 3'b101;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic    legal;
      logic    is_r;
      logic    is_shift;
      alu_op_e op;
   } dec_t;

   // SLTU/SLTIU fall to the default arm; SRA/SRAI fail the funct7 check on f3=101.
   function automatic dec_t decode(input logic [31:0] inst);
      dec_t d;
      logic f7_zero;
      logic f7_alt;
      logic plain_ok;
      d.is_r     = (inst[6:0] == OPC_OP);
      d.is_shift = 1'b0;
      d.op       = ALU_ADD;
      d.legal    = 1'b0;
      f7_zero    = (inst[31:25] == F7_BASE);
      f7_alt     = (inst[31:25] == F7_ALT);
      plain_ok   = !d.is_r || f7_zero;
      if (d.is_r || inst[6:0] == OPC_OP_IMM) begin
         case (inst[14:12])
            F3_ADD: begin
               d.legal = plain_ok || (d.is_r && f7_alt);
               d.op    = (d.is_r && f7_alt) ? ALU_SUB : ALU_ADD;
            end
            F3_SLL: begin d.legal = f7_zero;  d.is_shift = 1'b1; d.op = ALU_SLL; end
            F3_SLT: begin d.legal = plain_ok; d.op = ALU_SLT; end
            F3_XOR: begin d.legal = plain_ok; d.op = ALU_XOR; end
            F3_SRL: begin d.legal = f7_zero;  d.is_shift = 1'b1; d.op = ALU_SRL; end
            F3_OR:  begin d.legal = plain_ok; d.op = ALU_OR;  end
            F3_AND: begin d.legal = plain_ok; d.op = ALU_AND; end
            default: ;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 32x32 architectural register file: two combinational reads, one synchronous write,
// synchronous clear; x0 always reads zero and ignores writes.
module alu_issue_regfile
   import alu_issue_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [RAW-1:0]  ra1,
   output logic [XLEN-1:0] rd1,
   input  logic [RAW-1:0]  ra2,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [RAW-1:0]  wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (we && wa != '0) regs_d[wa] = wd;
      regs_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) regs_q <= '{default: '0};
      else     regs_q <= regs_d;
   end

   assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage feeding a registered ALU: one RV32I ALU op per cycle,
// RAW stall against the EX slot and bypass of the writeback value.
module alu_issue
   import alu_issue_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            inst_valid,
   input  logic [31:0]     inst,
   output logic            inst_ready,
   output logic [XLEN-1:0] alu_d1,
   output logic [XLEN-1:0] alu_d2,
   output logic [2:0]      alu_op,
   input  logic [XLEN-1:0] alu_dout,
   output logic            retire_valid,
   output logic [RAW-1:0]  retire_rd,
   output logic            illegal
);

   dec_t            dec;
   logic [RAW-1:0]  rs1, rs2, rd;
   logic [XLEN-1:0] rf_rd1, rf_rd2, opnd1, opnd2, imm;
   logic            stall, xfer, issue;

   logic [XLEN-1:0] alu_d1_q, alu_d1_d, alu_d2_q, alu_d2_d;
   alu_op_e         alu_op_q, alu_op_d;
   logic            ex_valid_q, ex_valid_d, wb_valid_q, wb_valid_d;
   logic [RAW-1:0]  ex_rd_q, ex_rd_d, wb_rd_q, wb_rd_d;
   logic            illegal_q, illegal_d;

   assign dec = decode(inst);
   assign rs1 = inst[19:15];
   assign rs2 = inst[24:20];
   assign rd  = inst[11:7];

   alu_issue_regfile u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs1),
      .rd1 (rf_rd1),
      .ra2 (rs2),
      .rd2 (rf_rd2),
      .we  (wb_valid_q),
      .wa  (wb_rd_q),
      .wd  (alu_dout)
   );

   always_comb begin
      // Only the EX slot can stall; the WB slot is covered by the bypass below.
      stall = ex_valid_q && (ex_rd_q != '0) &&
              ((ex_rd_q == rs1) || (dec.is_r && (ex_rd_q == rs2)));
      inst_ready = !rst && !stall;
      xfer  = inst_valid && inst_ready;
      issue = xfer && dec.legal;

      opnd1 = (wb_valid_q && wb_rd_q != '0 && wb_rd_q == rs1) ? alu_dout : rf_rd1;
      opnd2 = (wb_valid_q && wb_rd_q != '0 && wb_rd_q == rs2) ? alu_dout : rf_rd2;
      imm   = dec.is_shift ? XLEN'(inst[24:20]) : {{20{inst[31]}}, inst[31:20]};

      alu_d1_d   = '0;
      alu_d2_d   = '0;
      alu_op_d   = ALU_ADD;
      ex_rd_d    = '0;
      ex_valid_d = issue;
      if (issue) begin
         alu_d1_d = opnd1;
         alu_d2_d = !dec.is_r    ? imm :
                    dec.is_shift ? {{(XLEN-5){1'b0}}, opnd2[4:0]} : opnd2;
         alu_op_d = dec.op;
         ex_rd_d  = rd;
      end
      wb_valid_d = ex_valid_q;
      wb_rd_d    = ex_rd_q;
      illegal_d  = xfer && !dec.legal;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_d1_q   <= '0;
         alu_d2_q   <= '0;
         alu_op_q   <= ALU_ADD;
         ex_valid_q <= 1'b0;
         ex_rd_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         illegal_q  <= 1'b0;
      end else begin
         alu_d1_q   <= alu_d1_d;
         alu_d2_q   <= alu_d2_d;
         alu_op_q   <= alu_op_d;
         ex_valid_q <= ex_valid_d;
         ex_rd_q    <= ex_rd_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         illegal_q  <= illegal_d;
      end
   end

   assign alu_d1       = alu_d1_q;
   assign alu_d2       = alu_d2_q;
   assign alu_op       = alu_op_q;
   assign retire_valid = wb_valid_q;
   assign retire_rd    = wb_rd_q;
   assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: architectural-level model (register values updated at issue),
// a registered ALU stand-in, a per-cycle compare process and hand-computed pins.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_valid = 1'b0;
   logic [31:0] inst = '0;
   logic        inst_ready;
   logic [31:0] alu_d1, alu_d2;
   logic [2:0]  alu_op;
   logic [31:0] alu_dout = '0;
   logic        retire_valid;
   logic [4:0]  retire_rd;
   logic        illegal;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   alu_issue dut (
      .clk          (clk),
      .rst          (rst),
      .inst_valid   (inst_valid),
      .inst         (inst),
      .inst_ready   (inst_ready),
      .alu_d1       (alu_d1),
      .alu_d2       (alu_d2),
      .alu_op       (alu_op),
      .alu_dout     (alu_dout),
      .retire_valid (retire_valid),
      .retire_rd    (retire_rd),
      .illegal      (illegal)
   );

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a | b;
         3'd3: return a ^ b;
         3'd4: return a & b;
         3'd5: return a >> b[4:0];
         3'd6: return a << b[4:0];
         default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
   endfunction

   // Registered ALU downstream of the stage.
   always @(posedge clk) alu_dout <= alu_f(alu_d1, alu_d2, alu_op);

   function automatic logic [2:0] op_of_f3(input logic [2:0] f3);
      case (f3)
         3'd0: return 3'd0;
         3'd1: return 3'd6;
         3'd2: return 3'd7;
         3'd4: return 3'd3;
         3'd5: return 3'd5;
         3'd6: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Returns {legal, op}.
   function automatic logic [3:0] bdec(input logic [31:0] w);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = w[14:12];
      f7 = w[31:25];
      if (w[6:0] == 7'b0110011) begin
         if (f3 == 3'd0 && f7 == 7'h20) return {1'b1, 3'd1};
         return {(f3 != 3'd3 && f7 == 7'h00), op_of_f3(f3)};
      end
      if (w[6:0] == 7'b0010011)
         return {(f3 != 3'd3 && ((f3 != 3'd1 && f3 != 3'd5) || f7 == 7'h00)), op_of_f3(f3)};
      return 4'b0000;
   endfunction

   function automatic logic [31:0] addi(input int rd, input int rs1, input logic [11:0] imm);
      return {imm, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
   endfunction
   function automatic logic [31:0] ri(input logic [2:0] f3, input int rd, input int rs1,
                                      input logic [11:0] imm);
      return {imm, 5'(rs1), f3, 5'(rd), 7'b0010011};
   endfunction
   function automatic logic [31:0] rr(input logic [6:0] f7, input logic [2:0] f3, input int rd,
                                      input int rs1, input int rs2);
      return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
   endfunction

   // Model state: values the architecture holds once every accepted op has taken effect.
   logic [31:0] arch [32];
   logic [31:0] e_d1 = '0, e_d2 = '0;
   logic [2:0]  e_op = '0;
   logic        e_ill = 1'b0, e_ret_v = 1'b0;
   logic [4:0]  e_ret_rd = '0;
   logic        last_v = 1'b0;
   logic [4:0]  last_rd = '0;
   logic        exp_ready = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("inst_ready", 32'(inst_ready), 32'(exp_ready));
         chk("alu_d1", alu_d1, e_d1);
         chk("alu_d2", alu_d2, e_d2);
         chk("alu_op", 32'(alu_op), 32'(e_op));
         chk("illegal", 32'(illegal), 32'(e_ill));
         chk("retire_valid", 32'(retire_valid), 32'(e_ret_v));
         if (e_ret_v) chk("retire_rd", 32'(retire_rd), 32'(e_ret_rd));
      end
   end

   // Advance the model across the edge just taken, using the inputs held during it.
   task automatic commit();
      logic [3:0]  d;
      logic [31:0] a, b;
      if (rst) begin
         foreach (arch[i]) arch[i] = '0;
         e_d1 = '0; e_d2 = '0; e_op = '0; e_ill = 0; e_ret_v = 0; e_ret_rd = '0;
         last_v = 0; last_rd = '0;
         return;
      end
      e_ret_v = last_v; e_ret_rd = last_rd;
      e_d1 = '0; e_d2 = '0; e_op = '0; e_ill = 0; last_v = 0; last_rd = '0;
      if (inst_valid && exp_ready) begin
         d = bdec(inst);
         if (!d[3]) e_ill = 1;
         else begin
            a = arch[inst[19:15]];
            if (inst[6:0] == 7'b0110011)
               b = (d[2:0] == 3'd5 || d[2:0] == 3'd6) ? (arch[inst[24:20]] & 32'h1F)
                                                     : arch[inst[24:20]];
            else
               b = (d[2:0] == 3'd5 || d[2:0] == 3'd6) ? {27'd0, inst[24:20]}
                                                     : {{20{inst[31]}}, inst[31:20]};
            e_d1 = a; e_d2 = b; e_op = d[2:0];
            if (inst[11:7] != 0) arch[inst[11:7]] = alu_f(a, b, d[2:0]);
            last_v = 1; last_rd = inst[11:7];
         end
      end
   endtask

   task automatic apply(input logic v, input logic [31:0] w, input logic r);
      inst_valid = v; inst = w; rst = r;
      exp_ready = !r && !(last_v && last_rd != 0 &&
                  (last_rd == w[19:15] || (w[6:0] == 7'b0110011 && last_rd == w[24:20])));
   endtask

   task automatic cyc(input logic v, input logic [31:0] w, input logic r);
      @(posedge clk); #2;
      commit();
      apply(v, w, r);
   endtask

   task automatic idle();
      cyc(1'b0, 32'd0, 1'b0);
   endtask

   // Present w until the model says it transfers; count cycles the DUT held it off.
   task automatic issue(input logic [31:0] w, output int stalls);
      stalls = 0;
      cyc(1'b1, w, 1'b0);
      #1 if (!inst_ready) stalls++;
      for (int k = 0; k < 4 && !exp_ready; k++) begin
         cyc(1'b1, w, 1'b0);
         #1 if (!inst_ready) stalls++;
      end
   endtask

   task automatic issue_show(input logic [31:0] w);
      int s;
      issue(w, s);
      idle();
   endtask

   initial begin
      int s;
      foreach (arch[i]) arch[i] = '0;
      cyc(1'b0, 32'd0, 1'b1);
      chk_en = 1'b1;
      chk("rst_ready", 32'(inst_ready), 32'd0);
      chk("rst_d1", alu_d1, 32'd0);
      chk("rst_retire", 32'(retire_valid), 32'd0);
      idle();

      // Back-to-back independent ADDIs.
      issue(addi(1, 0, 12'd5), s);
      issue(addi(2, 0, 12'hFFD), s);
      chk("addi5_d2", alu_d2, 32'd5);
      chk("addi_no_stall", 32'(s), 32'd0);
      idle();
      chk("addim3_d2", alu_d2, 32'hFFFF_FFFD);
      chk("ret_rd1", 32'(retire_rd), 32'd1);
      idle();
      chk("ret_rd2", 32'(retire_rd), 32'd2);

      // Dependent pair: one bubble, then bypass.
      issue(addi(1, 0, 12'd7), s);
      issue(rr(7'h00, 3'b000, 3, 1, 1), s);
      chk("raw_stall", 32'(s), 32'd1);
      idle();
      chk("byp_d1", alu_d1, 32'd7);
      chk("byp_d2", alu_d2, 32'd7);

      // x5 = 0x80000000, x6 = 1, SLT and wrapping SUB.
      issue_show(addi(5, 0, 12'd1));
      issue_show(ri(3'b001, 5, 5, 12'd31));
      issue_show(addi(6, 0, 12'd1));
      issue_show(rr(7'h00, 3'b010, 7, 5, 6));
      chk("slt_op", 32'(alu_op), 32'd7);
      issue_show(rr(7'h20, 3'b000, 8, 6, 5));
      chk("sub_op", 32'(alu_op), 32'd1);
      issue_show(addi(12, 7, 12'd0));
      chk("x7_val", alu_d1, 32'd1);
      issue_show(addi(13, 8, 12'd0));
      chk("x8_val", alu_d1, 32'h8000_0001);
      issue_show(addi(14, 3, 12'd0));
      chk("x3_val", alu_d1, 32'd14);

      // Shift amount masking.
      issue_show(addi(9, 0, 12'd33));
      issue_show(rr(7'h00, 3'b001, 10, 6, 9));
      chk("sll_mask_d2", alu_d2, 32'd1);
      issue_show(ri(3'b101, 11, 5, 12'd31));
      chk("srli_d2", alu_d2, 32'd31);
      issue_show(rr(7'h00, 3'b000, 16, 10, 11));
      chk("x10_val", alu_d1, 32'd2);
      chk("x11_val", alu_d2, 32'd1);

      // Illegal words: SRAI and SLTU.
      issue(32'h4010_D093, s);
      idle();
      chk("srai_illegal", 32'(illegal), 32'd1);
      idle();
      chk("illegal_pulse", 32'(illegal), 32'd0);
      chk("ill_no_retire", 32'(retire_valid), 32'd0);
      issue_show(rr(7'h00, 3'b011, 15, 1, 2));
      chk("sltu_illegal", 32'(illegal), 32'd1);
      issue_show(addi(17, 1, 12'd0));
      chk("x1_kept", alu_d1, 32'd7);
      issue_show(addi(18, 15, 12'd0));
      chk("x15_kept", alu_d1, 32'd0);

      // x0 writes are discarded but still retire.
      issue(addi(0, 0, 12'd9), s);
      issue(rr(7'h00, 3'b000, 4, 0, 0), s);
      chk("x0_no_stall", 32'(s), 32'd0);
      idle();
      chk("x0_retire_v", 32'(retire_valid), 32'd1);
      chk("x0_retire_rd", 32'(retire_rd), 32'd0);
      chk("x0_read_d1", alu_d1, 32'd0);
      issue_show(addi(19, 4, 12'd0));
      chk("x4_val", alu_d1, 32'd0);

      // Reset with an op in EX: dropped, registers cleared.
      issue(addi(20, 1, 12'd0), s);
      cyc(1'b0, 32'd0, 1'b1);
      idle();
      chk("rst_drop_ret0", 32'(retire_valid), 32'd0);
      idle();
      chk("rst_drop_ret1", 32'(retire_valid), 32'd0);
      issue_show(rr(7'h00, 3'b000, 21, 1, 2));
      chk("rst_x1", alu_d1, 32'd0);
      chk("rst_x2", alu_d2, 32'd0);
      issue_show(rr(7'h00, 3'b000, 22, 3, 8));
      chk("rst_x3", alu_d1, 32'd0);
      chk("rst_x8", alu_d2, 32'd0);
      idle();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
